// File: rtl/reg16_bank_arbiter_pkg.sv
// Shared definitions for the 16-bit register bank arbiter: FSM encoding and default widths.
package reg16_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W     = 8;

endpackage

// File: rtl/reg16_bank_arbiter_if.sv
// Requester/read bus of the register bank arbiter. The master drives requests and the read address.
// The slave returns ready, grant and status, read data and the FSM state.
interface reg16_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int GW    = 2,
    parameter int AW    = 2,
    parameter int WIDTH = 16
) ();
    import reg16_arb_pkg::*;

    // Handshake: a requester holds req_valid, addr and data stable until its req_ready bit
    // is 1. The write transfers on the rising edge where valid and ready are both 1.
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [GW-1:0]         grant_id;
    logic                  busy;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic [CNT_W-1:0]      wr_count;
    state_t                state_dbg;

    modport master (
        output req_valid, req_addr, req_data, rd_addr,
        input  req_ready, grant_id, busy, rd_data, wr_count, state_dbg
    );

    modport slave (
        input  req_valid, req_addr, req_data, rd_addr,
        output req_ready, grant_id, busy, rd_data, wr_count, state_dbg
    );

endinterface

// File: rtl/reg16_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first set request at or after ptr, with wraparound.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int GW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic            any,
    output logic [GW-1:0]   winner
);

    int idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg16_bank_arbiter.sv
// Round-robin write arbiter in front of a DEPTH x WIDTH register bank, with a combinational read port.
// A two-state FSM grants one requester per IDLE->GRANT->IDLE cycle.
module reg16_bank_arbiter
    import reg16_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int GW    = 2,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic reset,
    reg16_bank_arbiter_if.slave bus
);

    state_t           state_q;
    logic [GW-1:0]    grant_q;
    logic [GW-1:0]    rr_ptr_q;
    logic [GW-1:0]    rr_ptr_d;
    logic [CNT_W-1:0] wr_count_q;
    logic [CNT_W-1:0] wr_count_d;
    logic [WIDTH-1:0] bank_q [DEPTH];

    logic             arb_any;
    logic [GW-1:0]    arb_winner;
    logic             commit;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [NREQ-1:0]  ready_c;

    rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_rr (
        .req    (bus.req_valid),
        .ptr    (rr_ptr_q),
        .any    (arb_any),
        .winner (arb_winner)
    );

    // Select the granted requester's slice; ready mirrors its valid only while in GRANT.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        commit  = 1'b0;
        ready_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == GW'(i)) begin
                wr_addr = bus.req_addr[i*AW +: AW];
                wr_data = bus.req_data[i*WIDTH +: WIDTH];
                if (state_q == ST_GRANT) begin
                    commit     = bus.req_valid[i];
                    ready_c[i] = bus.req_valid[i];
                end
            end
        end
        rr_ptr_d   = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
        wr_count_d = wr_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            wr_count_q <= '0;
            for (int j = 0; j < DEPTH; j++) bank_q[j] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_q <= arb_winner;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    state_q <= ST_IDLE;
                    // A withdrawn request drops the write and leaves the pointer in place.
                    if (commit) begin
                        bank_q[wr_addr] <= wr_data;
                        wr_count_q      <= wr_count_d;
                        rr_ptr_q        <= rr_ptr_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q == ST_GRANT);
    assign bus.wr_count  = wr_count_q;
    assign bus.rd_data   = bank_q[bus.rd_addr];
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_reg16_bank_arbiter.sv
// Directed bench for reg16_bank_arbiter: reset, single write, round robin, same address,
// withdrawal, asynchronous reset mid-grant and write-counter wrap.
module tb_reg16_bank_arbiter;
    import reg16_arb_pkg::*;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    reg16_bank_arbiter_if bus ();

    reg16_bank_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, and outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.req_valid = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.req_valid = 4'($urandom_range(1, 15));
        bus.req_addr  = 8'($urandom);
        bus.req_data  = {$urandom, $urandom};
        bus.rd_addr   = '0;
        repeat (3) tick();
        total_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", bus.req_ready); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.wr_count !== 8'd0) $display("FAIL reset_wr_count: got %0d want 0", bus.wr_count); else pass_cnt++;
        total_cnt++; if (bus.grant_id !== 2'd0) $display("FAIL reset_grant: got %0d want 0", bus.grant_id); else pass_cnt++;
        for (int a = 0; a < 4; a++) begin
            bus.rd_addr = 2'(a);
            #1;
            total_cnt++; if (bus.rd_data !== 16'h0000) $display("FAIL reset_rd_data[%0d]: got %h want 0000", a, bus.rd_data); else pass_cnt++;
        end
        bus.req_valid = '0;
        reset = 1'b1;
        tick();
        tick();
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL idle_after_reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.state_dbg !== ST_IDLE) $display("FAIL idle_after_reset_state: got %0d want 0", bus.state_dbg); else pass_cnt++;
    endtask

    task automatic test_single_write();
        bus.req_addr[2*2 +: 2]   = 2'd3;
        bus.req_data[2*16 +: 16] = 16'hA5F0;
        bus.rd_addr              = 2'd3;
        bus.req_valid            = 4'b0100;
        tick();
        total_cnt++; if (bus.grant_id !== 2'd2) $display("FAIL single_grant: got %0d want 2", bus.grant_id); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", bus.req_ready); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 16'h0000) $display("FAIL single_old_data: got %h want 0000", bus.rd_data); else pass_cnt++;
        tick();
        bus.req_valid = '0;
        #1;
        total_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL single_ready_drop: got %b want 0000", bus.req_ready); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 16'hA5F0) $display("FAIL single_rd_data: got %h want a5f0", bus.rd_data); else pass_cnt++;
        total_cnt++; if (bus.wr_count !== 8'd1) $display("FAIL single_wr_count: got %0d want 1", bus.wr_count); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int exp_g;
        do_reset();
        bus.req_addr = {2'd3, 2'd2, 2'd1, 2'd0};
        bus.req_data = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = k % 4;
            bus.rd_addr = 2'(exp_g);
            tick();
            total_cnt++; if (bus.grant_id !== 2'(exp_g)) $display("FAIL rr_grant[%0d]: got %0d want %0d", k, bus.grant_id, exp_g); else pass_cnt++;
            total_cnt++; if (bus.req_ready !== 4'(1 << exp_g)) $display("FAIL rr_ready[%0d]: got %b want %b", k, bus.req_ready, 4'(1 << exp_g)); else pass_cnt++;
            tick();
            total_cnt++; if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) $display("FAIL rr_gap[%0d]: got busy=%b ready=%b want 0/0000", k, bus.busy, bus.req_ready); else pass_cnt++;
            total_cnt++; if (bus.rd_data !== 16'hB000 + 16'(exp_g)) $display("FAIL rr_rd_data[%0d]: got %h want %h", k, bus.rd_data, 16'hB000 + 16'(exp_g)); else pass_cnt++;
            total_cnt++; if (bus.wr_count !== 8'(k + 1)) $display("FAIL rr_wr_count[%0d]: got %0d want %0d", k, bus.wr_count, k + 1); else pass_cnt++;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_same_address();
        do_reset();
        bus.req_addr[0*2 +: 2]   = 2'd1;
        bus.req_addr[3*2 +: 2]   = 2'd1;
        bus.req_data[0*16 +: 16] = 16'h1111;
        bus.req_data[3*16 +: 16] = 16'h3333;
        bus.rd_addr   = 2'd1;
        bus.req_valid = 4'b1001;
        tick();
        total_cnt++; if (bus.grant_id !== 2'd0) $display("FAIL same_first_grant: got %0d want 0", bus.grant_id); else pass_cnt++;
        tick();
        bus.req_valid[0] = 1'b0;
        total_cnt++; if (bus.rd_data !== 16'h1111) $display("FAIL same_first_data: got %h want 1111", bus.rd_data); else pass_cnt++;
        tick();
        total_cnt++; if (bus.grant_id !== 2'd3) $display("FAIL same_second_grant: got %0d want 3", bus.grant_id); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 16'h1111) $display("FAIL same_old_during_grant: got %h want 1111", bus.rd_data); else pass_cnt++;
        tick();
        bus.req_valid = '0;
        total_cnt++; if (bus.rd_data !== 16'h3333) $display("FAIL same_final_data: got %h want 3333", bus.rd_data); else pass_cnt++;
        total_cnt++; if (bus.wr_count !== 8'd2) $display("FAIL same_wr_count: got %0d want 2", bus.wr_count); else pass_cnt++;
    endtask

    task automatic test_withdrawal();
        // The pointer is 0 after req3 committed, so req1 beats req2.
        bus.req_addr[1*2 +: 2]   = 2'd2;
        bus.req_addr[2*2 +: 2]   = 2'd0;
        bus.req_data[1*16 +: 16] = 16'h2222;
        bus.req_data[2*16 +: 16] = 16'h4444;
        bus.rd_addr   = 2'd2;
        bus.req_valid = 4'b0110;
        tick();
        total_cnt++; if (bus.grant_id !== 2'd1) $display("FAIL wd_grant: got %0d want 1", bus.grant_id); else pass_cnt++;
        bus.req_valid[1] = 1'b0;
        #1;
        total_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL wd_ready: got %b want 0000", bus.req_ready); else pass_cnt++;
        tick();
        total_cnt++; if (bus.wr_count !== 8'd2) $display("FAIL wd_wr_count: got %0d want 2", bus.wr_count); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 16'h0000) $display("FAIL wd_bank: got %h want 0000", bus.rd_data); else pass_cnt++;
        bus.req_valid[1] = 1'b1;
        tick();
        total_cnt++; if (bus.grant_id !== 2'd1) $display("FAIL wd_regrant: got %0d want 1", bus.grant_id); else pass_cnt++;
        tick();
        bus.req_valid = '0;
        total_cnt++; if (bus.rd_data !== 16'h2222) $display("FAIL wd_commit_data: got %h want 2222", bus.rd_data); else pass_cnt++;
        total_cnt++; if (bus.wr_count !== 8'd3) $display("FAIL wd_commit_count: got %0d want 3", bus.wr_count); else pass_cnt++;
    endtask

    task automatic test_reset_wrap();
        bus.req_addr[0*2 +: 2]   = 2'd1;
        bus.req_data[0*16 +: 16] = 16'hDEAD;
        bus.rd_addr   = 2'd1;
        bus.req_valid = 4'b0001;
        tick();
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", bus.busy); else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++; if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) $display("FAIL abort_status: got busy=%b ready=%b want 0/0000", bus.busy, bus.req_ready); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 16'h0000) $display("FAIL abort_bank: got %h want 0000", bus.rd_data); else pass_cnt++;
        total_cnt++; if (bus.wr_count !== 8'd0 || bus.grant_id !== 2'd0) $display("FAIL abort_regs: got count=%0d grant=%0d want 0/0", bus.wr_count, bus.grant_id); else pass_cnt++;
        bus.req_valid = '0;
        tick();
        reset = 1'b1;
        bus.req_valid = 4'b0001;
        for (int i = 0; i < 256; i++) begin
            bus.req_data[0*16 +: 16] = 16'(i);
            tick();
            tick();
            if (i == 254) begin
                total_cnt++; if (bus.wr_count !== 8'd255) $display("FAIL wrap_255: got %0d want 255", bus.wr_count); else pass_cnt++;
            end
        end
        bus.req_valid = '0;
        total_cnt++; if (bus.wr_count !== 8'd0) $display("FAIL wrap_0: got %0d want 0", bus.wr_count); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 16'd255) $display("FAIL wrap_last_data: got %h want 00ff", bus.rd_data); else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rd_addr   = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_same_address();
        test_withdrawal();
        test_reset_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
